score_keeper: RTL
=================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 9, meaning the goals needed to win (legal range 1..9).
REQ-002 The block SHALL have parameter SERVE_TICKS, default 60, meaning the dyn_clk cycles of pause before a serve (legal range 1..255).
REQ-003 The block SHALL have port dyn_clk, input, 1 bit: the dynamic game clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: level from the start/serve button.
REQ-006 The block SHALL have port goal_ply1, input, 1 bit: level, high while the ball sits at the right wall (player 1 scores).
REQ-007 The block SHALL have port goal_ply2, input, 1 bit: level, high while the ball sits at the left wall (player 2 scores).
REQ-008 The block SHALL have port reset_goals, input, 1 bit: level request to clear the match.
REQ-009 The block SHALL have port score_ply1, output, 4 bits: player 1 score in BCD, 0..9.
REQ-010 The block SHALL have port score_ply2, output, 4 bits: player 2 score in BCD, 0..9.
REQ-011 The block SHALL have port play, output, 1 bit: high only while the ball is in play.
REQ-012 The block SHALL have port reset_ball, output, 1 bit: one-cycle pulse that recentres the ball.
REQ-013 The block SHALL have port game_over, output, 1 bit: high in the GAME_OVER state.
REQ-014 The block SHALL have port winner, output, 2 bits: 00 none, 01 player 1, 10 player 2.

Function
REQ-015 The FSM SHALL have four states: IDLE, SERVE, PLAY and GAME_OVER.
REQ-016 start, goal_ply1 and goal_ply2 SHALL each be rising-edge detected against a registered copy of the previous cycle's value; each registered copy SHALL reset to 0.
REQ-017 IDLE: play=0; a start rise SHALL move the FSM to SERVE.
REQ-018 On every entry to SERVE, reset_ball SHALL be 1 for exactly the first cycle, and the serve counter SHALL load SERVE_TICKS-1.
REQ-019 SERVE: play=0; the counter SHALL decrement once per cycle, and the FSM SHALL move to PLAY on the cycle after the counter reads 0, so that SERVE lasts exactly SERVE_TICKS cycles.
REQ-020 PLAY: play=1; a goal_ply1 rise alone SHALL increment score_ply1, and a goal_ply2 rise alone SHALL increment score_ply2, on the cycle after the edge.
REQ-021 After a score update, the FSM SHALL move to GAME_OVER if the new score equals WIN_SCORE, otherwise to SERVE.
REQ-022 Simultaneous goal_ply1 and goal_ply2 rises in the same cycle SHALL leave both scores unchanged and move the FSM to SERVE.
REQ-023 Goal edges outside PLAY SHALL be ignored, and a goal level held high across the transition into PLAY SHALL NOT score.
REQ-024 Scores SHALL saturate at 9 and never wrap.
REQ-025 GAME_OVER: play=0, game_over=1, and winner SHALL hold the scorer of the winning goal; a start rise SHALL clear both scores, clear winner and move the FSM to SERVE.
REQ-026 reset_goals=1 SHALL synchronously, from any state, clear both scores, clear winner and force IDLE; this SHALL take priority over all goal and start events in that cycle, and reset_ball SHALL NOT pulse.
REQ-027 All outputs SHALL be registered with no combinational input-to-output path.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, score_ply1=0, score_ply2=0, play=0, reset_ball=0, game_over=0, winner=00, serve counter=0 and all edge registers=0.
REQ-029 Release of reset_n SHALL take effect at the next dyn_clk edge, and a start held high through release SHALL NOT count as a rise.

Verification
REQ-030 Reset, then a start pulse -> reset_ball is high for 1 cycle and play rises exactly 60 cycles after entering SERVE.
REQ-031 In PLAY, goal_ply1 held high for 5 cycles -> score_ply1 increments by exactly 1 (0->1), play=0, and the FSM re-enters SERVE.
REQ-032 With WIN_SCORE=3, three player 2 goals -> score_ply2=3, game_over=1, winner=10; a further goal_ply2 does not change the score; start -> scores 0 and SERVE.
REQ-033 goal_ply1 and goal_ply2 rising in the same PLAY cycle -> scores unchanged and SERVE entered.
REQ-034 reset_goals asserted mid-SERVE and again in GAME_OVER -> scores 0, IDLE, no reset_ball pulse.
REQ-035 reset_n asserted mid-PLAY with score 4:2 -> all outputs 0 immediately without waiting for a dyn_clk edge.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: match state for a two-player ball game.
// Tracks IDLE/SERVE/PLAY/GAME_OVER, BCD scores, serve pause and winner.
// Every output comes straight from a flop.
module score_keeper #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 60
) (
  input  logic       dyn_clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       goal_ply1,
  input  logic       goal_ply2,
  input  logic       reset_goals,
  output logic [3:0] score_ply1,
  output logic [3:0] score_ply2,
  output logic       play,
  output logic       reset_ball,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, GAME_OVER} state_t;

  localparam logic [3:0] WIN_BCD    = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_TICKS - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0] winner_q, winner_d;
  logic       play_q, play_d, rb_q, rb_d, go_q, go_d;
  logic       start_prev_q, g1_prev_q, g2_prev_q, armed_q;
  logic       start_rise, g1_rise, g2_rise, p1_only, p2_only;
  logic [3:0] s1_inc, s2_inc;
  logic       win_hit;

  // BCD score increment that sticks at 9 instead of wrapping
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= 4'd9) ? 4'd9 : s + 4'd1;
  endfunction

  // armed_q blocks the first cycle after reset so a level held through
  // release never looks like a fresh press
  assign start_rise = armed_q & start     & ~start_prev_q;
  assign g1_rise    = armed_q & goal_ply1 & ~g1_prev_q;
  assign g2_rise    = armed_q & goal_ply2 & ~g2_prev_q;
  assign p1_only    = g1_rise & ~g2_rise;
  assign p2_only    = g2_rise & ~g1_rise;
  assign s1_inc     = sat_inc(s1_q);
  assign s2_inc     = sat_inc(s2_q);
  assign win_hit    = (p1_only && s1_inc == WIN_BCD) || (p2_only && s2_inc == WIN_BCD);

  // previous-cycle copies of the button and goal levels for edge detection
  always_ff @(posedge dyn_clk or negedge reset_n) begin
    if (!reset_n) begin
      start_prev_q <= 1'b0;
      g1_prev_q    <= 1'b0;
      g2_prev_q    <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      start_prev_q <= start;
      g1_prev_q    <= goal_ply1;
      g2_prev_q    <= goal_ply2;
      armed_q      <= 1'b1;
    end
  end

  // state, datapath and registered outputs
  always_ff @(posedge dyn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      s1_q     <= 4'd0;
      s2_q     <= 4'd0;
      winner_q <= 2'b00;
      play_q   <= 1'b0;
      rb_q     <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      winner_q <= winner_d;
      play_q   <= play_d;
      rb_q     <= rb_d;
      go_q     <= go_d;
    end
  end

  // next-state decision; reset_goals overrides every other event
  always_comb begin
    state_d = state_q;
    if (reset_goals) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      if (start_rise) state_d = SERVE;
        SERVE:     if (cnt_q == 8'd0) state_d = PLAY;
        PLAY: begin
          if (p1_only || p2_only) state_d = win_hit ? GAME_OVER : SERVE;
          else if (g1_rise && g2_rise) state_d = SERVE;
        end
        GAME_OVER: if (start_rise) state_d = SERVE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // scores, winner and serve counter
  always_comb begin
    s1_d     = s1_q;
    s2_d     = s2_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    if (reset_goals) begin
      s1_d     = 4'd0;
      s2_d     = 4'd0;
      winner_d = 2'b00;
    end else if (state_q == PLAY) begin
      if (p1_only) begin
        s1_d = s1_inc;
        if (win_hit) winner_d = 2'b01;
      end else if (p2_only) begin
        s2_d = s2_inc;
        if (win_hit) winner_d = 2'b10;
      end
    end else if (state_q == GAME_OVER && start_rise) begin
      s1_d     = 4'd0;
      s2_d     = 4'd0;
      winner_d = 2'b00;
    end
    if (state_d == SERVE && state_q != SERVE) cnt_d = SERVE_LOAD;
    else if (state_q == SERVE && cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
  end

  // outputs follow the state being entered so they line up with it
  always_comb begin
    play_d = (state_d == PLAY);
    go_d   = (state_d == GAME_OVER);
    rb_d   = (state_d == SERVE) && (state_q != SERVE);
  end

  assign score_ply1 = s1_q;
  assign score_ply2 = s2_q;
  assign winner     = winner_q;
  assign play       = play_q;
  assign reset_ball = rb_q;
  assign game_over  = go_q;

endmodule
